// File: rtl/tick_scheduler.sv
// tick_scheduler: shared prescaler plus one round-robin arbitrated
// tick countdown timer, time-multiplexed among NREQ requesters.
// The prescaler runs freely from reset and is never restarted by the
// arbiter. Only ticks seen while a delay is running are counted.
module tick_scheduler #(
  parameter int NREQ     = 4,
  parameter int PRESCALE = 2500,
  parameter int CW       = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*CW-1:0]   req_ticks,
  input  logic                 cancel,
  output logic                 tick,
  output logic                 clk_div,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 busy
);

  // Prescaler counter width; a PRESCALE of 0 still needs one bit.
  localparam int PW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
  // Requester index width (NREQ >= 2, so at least one bit).
  localparam int IW = $clog2(NREQ);

  localparam logic [PW-1:0]   PC_MAX   = PW'(PRESCALE);
  // After reset the pointer sits on the last requester, so the search
  // starts at requester 0.
  localparam logic [IW-1:0]   LAST_RST = IW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Registers and their next-state values
  logic [PW-1:0]   pc_q,      pc_d;
  logic            tick_q,    tick_d;
  logic            clk_div_q, clk_div_d;
  state_t          state_q,   state_d;
  logic [NREQ-1:0] gnt_q,     gnt_d;
  logic [NREQ-1:0] done_q,    done_d;
  logic [CW-1:0]   cnt_q,     cnt_d;
  logic [IW-1:0]   last_q,    last_d;

  // Arbitration results
  logic            win_found_s;
  logic [IW-1:0]   win_idx_s;
  logic [CW-1:0]   win_ticks_s;

  // Derived conditions inside RUN
  logic            final_tick_s;

  // Free-running prescaler: wraps at PRESCALE, strobes tick and flips clk_div.
  always_comb begin
    if (pc_q == PC_MAX) begin
      pc_d      = '0;
      tick_d    = 1'b1;
      clk_div_d = ~clk_div_q;
    end else begin
      pc_d      = pc_q + PW'(1'b1);
      tick_d    = 1'b0;
      clk_div_d = clk_div_q;
    end
  end

  // Round-robin search starting one past the most recent grant, wrapping.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!win_found_s && req[(int'(last_q) + k) % NREQ]) begin
        win_found_s = 1'b1;
        win_idx_s   = IW'((int'(last_q) + k) % NREQ);
      end
    end
  end

  // Requested tick count of the current winner.
  always_comb begin
    win_ticks_s = req_ticks[int'(win_idx_s)*CW +: CW];
  end

  // Last counted tick of a running delay (cnt is never 0 while running).
  always_comb begin
    final_tick_s = tick_q && (cnt_q == CW'(1'b1));
  end

  // All registers: synchronous active-high reset to the idle state.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q      <= '0;
      tick_q    <= 1'b0;
      clk_div_q <= 1'b0;
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      done_q    <= '0;
      cnt_q     <= '0;
      last_q    <= LAST_RST;
    end else begin
      pc_q      <= pc_d;
      tick_q    <= tick_d;
      clk_div_q <= clk_div_d;
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
    end
  end

  // Next-state logic; cancel takes priority over the final tick in RUN.
  always_comb begin
    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          if (win_ticks_s != '0) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else if (final_tick_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath/output updates: grant, countdown, completion pulse, pointer.
  always_comb begin
    gnt_d  = gnt_q;
    done_d = done_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    case (state_q)
      ST_IDLE: begin
        done_d = '0;
        if (win_found_s) begin
          gnt_d  = ONE_HOT0 << win_idx_s;
          last_d = win_idx_s;
          cnt_d  = win_ticks_s;
          // A zero-length delay completes together with its grant.
          if (win_ticks_s == '0) begin
            done_d = ONE_HOT0 << win_idx_s;
          end else begin
            done_d = '0;
          end
        end else begin
          gnt_d = '0;
        end
      end
      ST_RUN: begin
        if (cancel) begin
          // Abort silently; the pointer keeps the cancelled requester.
          gnt_d  = '0;
          cnt_d  = '0;
          done_d = '0;
        end else if (final_tick_s) begin
          cnt_d  = '0;
          done_d = gnt_q;
        end else if (tick_q) begin
          cnt_d  = cnt_q - CW'(1'b1);
        end else begin
          cnt_d  = cnt_q;
        end
      end
      ST_DONE: begin
        gnt_d  = '0;
        done_d = '0;
        cnt_d  = '0;
      end
      default: begin
        gnt_d  = '0;
        done_d = '0;
        cnt_d  = '0;
      end
    endcase
  end

  // Output drive: registered strobes, busy decoded from the state register.
  always_comb begin
    tick    = tick_q;
    clk_div = clk_div_q;
    gnt     = gnt_q;
    done    = done_q;
    busy    = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler with PRESCALE=3, NREQ=4.
// A transaction-level model predicts every output on every cycle; the
// directed sequence adds hand-computed literal expectations.
module tb_tick_scheduler;

  localparam int NREQ = 4;
  localparam int P    = 3;
  localparam int CW   = 16;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*CW-1:0]  req_ticks = '0;
  logic                cancel = 1'b0;
  logic                tick, clk_div, busy;
  logic [NREQ-1:0]     gnt, done;

  int checks = 0;
  int failures = 0;

  tick_scheduler #(.NREQ(NREQ), .PRESCALE(P), .CW(CW)) dut (
    .clock(clock), .reset(reset), .req(req), .req_ticks(req_ticks),
    .cancel(cancel), .tick(tick), .clk_div(clk_div), .gnt(gnt),
    .done(done), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic void check(string name, int unsigned act, int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  int cyc = 0;           // edges since reset released
  int owner = -1;        // requester holding the timer, -1 when idle
  int rem = 0;           // ticks still to count
  int last_m = NREQ - 1;
  int model_w;
  bit in_done = 1'b0;
  bit found;
  bit model_ok = 1'b0;
  bit tick_m = 1'b0;
  bit prev_tick;
  logic [NREQ-1:0] gnt_m = '0, done_m = '0;

  always @(posedge clock) begin
    prev_tick = tick_m;
    if (reset) begin
      cyc = 0; owner = -1; rem = 0; last_m = NREQ - 1;
      in_done = 1'b0; gnt_m = '0; done_m = '0; model_ok = 1'b1;
    end else if (model_ok) begin
      if (in_done) begin
        in_done = 1'b0; owner = -1; gnt_m = '0; done_m = '0;
      end else if (owner < 0) begin
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
          model_w = (last_m + k) % NREQ;
          if (!found && req[model_w]) begin
            found = 1'b1; owner = model_w; last_m = model_w;
            rem = int'(req_ticks[model_w*CW +: CW]);
            gnt_m = 4'b0001 << model_w;
            if (rem == 0) begin
              in_done = 1'b1; done_m = gnt_m;
            end
          end
        end
      end else if (cancel) begin
        owner = -1; rem = 0; gnt_m = '0;
      end else if (prev_tick) begin
        rem = rem - 1;
        if (rem == 0) begin
          in_done = 1'b1; done_m = gnt_m;
        end
      end
      cyc = cyc + 1;
    end
    tick_m = (cyc > 0) && (cyc % (P + 1) == 0);
    #1;
    if (model_ok) begin
      check("model_tick", tick, tick_m);
      check("model_clk_div", clk_div, (cyc / (P + 1)) % 2);
      check("model_gnt", gnt, gnt_m);
      check("model_done", done, done_m);
      check("model_busy", busy, (owner >= 0) ? 1 : 0);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(negedge clock);
  endtask

  task automatic do_reset();
    req = '0; cancel = 1'b0; reset = 1'b1;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic set_ticks(input int t0, input int t1, input int t2, input int t3);
    req_ticks = {CW'(t3), CW'(t2), CW'(t1), CW'(t0)};
  endtask

  // Wait for a nonzero done (bounded); n returns cycles waited.
  task automatic wait_done(input string name, input int bound, output int n);
    n = 0;
    while (done == '0 && n < bound) begin
      step(); n++;
    end
    check(name, (done != '0) ? 1 : 0, 1);
  endtask

  task automatic wait_gnt(input string name, input int bound);
    int n;
    n = 0;
    while (gnt == '0 && n < bound) begin
      step(); n++;
    end
    check(name, (gnt != '0) ? 1 : 0, 1);
  endtask

  int n;
  int ticks_seen;
  int order[$];
  logic [NREQ-1:0] prev_gnt;

  initial begin
    // Test 1: idle after reset
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      step();
      check("t1_tick", tick, (k % 4 == 0) ? 1 : 0);
      check("t1_gnt_idle", {gnt, done, busy}, 0);
    end
    check("t1_clk_div_after_3_ticks", clk_div, 1);

    // Test 2: requester 0, three ticks
    set_ticks(3, 0, 0, 0);
    req = 4'b0001;
    step();
    check("t2_gnt", gnt, 4'b0001);
    check("t2_busy", busy, 1);
    wait_done("t2_done_seen", 40, n);
    check("t2_done_val", done, 4'b0001);
    check("t2_delay_in_range", (n >= 9 && n <= 12) ? 1 : 0, 1);
    req = '0;
    step();
    check("t2_gnt_released", gnt, 0);
    check("t2_done_one_cycle", done, 0);

    // Test 3: requester 2, zero ticks
    set_ticks(0, 0, 0, 0);
    req = 4'b0100;
    step();
    check("t3_gnt", gnt, 4'b0100);
    check("t3_done", done, 4'b0100);
    req = '0;
    step();
    check("t3_idle_busy", busy, 0);
    check("t3_idle_gnt", gnt, 0);

    // Test 4: all requesting, one tick each
    do_reset();
    set_ticks(1, 1, 1, 1);
    req = 4'b1111;
    prev_gnt = '0;
    n = 0;
    while (order.size() < 5 && n < 200) begin
      step(); n++;
      if (gnt != '0 && prev_gnt == '0) begin
        for (int i = 0; i < NREQ; i++) if (gnt[i]) order.push_back(i);
      end
      prev_gnt = gnt;
    end
    check("t4_grant_count", order.size(), 5);
    if (order.size() == 5) begin
      check("t4_order0", order[0], 0);
      check("t4_order1", order[1], 1);
      check("t4_order2", order[2], 2);
      check("t4_order3", order[3], 3);
      check("t4_order4", order[4], 0);
    end
    wait_done("t4_final_done", 40, n);
    req = '0;
    step(); step();

    // Test 5: cancel during requester 0's second tick
    do_reset();
    set_ticks(5, 5, 0, 0);
    req = 4'b0011;
    step();
    check("t5_gnt0", gnt, 4'b0001);
    ticks_seen = 0; n = 0;
    while (ticks_seen < 2 && n < 40) begin
      if (tick) ticks_seen++;
      if (ticks_seen < 2) begin
        step(); n++;
      end
    end
    check("t5_second_tick_found", ticks_seen, 2);
    cancel = 1'b1;
    req = 4'b0010;
    step();
    cancel = 1'b0;
    check("t5_gnt_after_cancel", gnt, 0);
    check("t5_no_done", done, 0);
    wait_gnt("t5_next_gnt_seen", 10);
    check("t5_next_gnt", gnt, 4'b0010);
    wait_done("t5_done1_seen", 40, n);
    check("t5_done1", done, 4'b0010);
    req = '0;
    step(); step();

    // Test 6: reset while requester 2 is running
    do_reset();
    set_ticks(3, 3, 3, 3);
    req = 4'b1111;
    n = 0;
    while (gnt != 4'b0100 && n < 100) begin
      step(); n++;
    end
    check("t6_gnt2_reached", gnt, 4'b0100);
    step(); step();
    check("t6_still_running", busy, 1);
    reset = 1'b1;
    step();
    check("t6_reset_outputs", {tick, clk_div, gnt, done, busy}, 0);
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 1) check("t6_first_gnt", gnt, 4'b0001);
      check("t6_tick_restart", tick, (k == 4) ? 1 : 0);
    end
    wait_done("t6_done0_seen", 40, n);
    check("t6_done0", done, 4'b0001);
    req = '0;
    step(); step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Shared timing controller that owns the system prescaler and time-multiplexes one tick-based countdown timer among `NREQ` requesters. It regenerates the divided clock (`clk_div`) and a one-cycle `tick` strobe from `clock`. It also arbitrates delay requests round-robin and signals completion to the winning requester with a one-cycle `done` pulse. It sits between the top-level clock/reset and the display/sequencing blocks that previously each needed their own divider.

## Interface
- `NREQ`, 4: number of requesters (≥2).
- `PRESCALE`, 2500: `tick` fires once every `PRESCALE+1` clock cycles; `clk_div` toggles on each tick.
- `CW`, 16: width of each requested tick count.

- `clock`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  NREQ  level request; bit i held by requester i until its `done[i]`.
- `req_ticks`  in  NREQ*CW  requested delay in ticks; requester i uses bits `[i*CW +: CW]`; must be stable while `req[i]` is high.
- `cancel`  in  1  abort the running delay.
- `tick`  out  1  one-cycle prescaler strobe.
- `clk_div`  out  1  divided clock, period `2*(PRESCALE+1)` cycles.
- `gnt`  out  NREQ  one-hot grant; all-zero when idle.
- `done`  out  NREQ  one-hot completion pulse, one cycle.
- `busy`  out  1  high whenever the FSM is not IDLE.

## Operation
- Prescaler: counter `pc` (width ≥ clog2(PRESCALE+1)), free-running, never restarted by grants or cancel.
  - `pc==PRESCALE`: `pc`←0, `tick`←1, `clk_div`←~`clk_div`.
  - Otherwise: `pc`←`pc`+1, `tick`←0.
- Round-robin pointer `last` holds the index of the most recent grant. The search starts at `last+1` mod NREQ and wraps.
- FSM states:
  - IDLE:
    - No `req`: stay.
    - Any `req`: select winner w. Set `gnt`←onehot(w), `last`←w, `cnt`←`req_ticks[w]`.
    - Next state is RUN if the count is nonzero, DONE if the count is 0.
  - RUN: on `tick`, `cnt`←`cnt`−1. If `tick && cnt==1`: `cnt`←0 and state←DONE with `done`←`gnt`.
  - DONE: lasts exactly one cycle; `done` and `gnt` are both high. Then `gnt`←0, `done`←0, state←IDLE.
  - `cancel` in RUN: `gnt`←0, `cnt`←0, state←IDLE, no `done`; `last` is kept. `cancel` in IDLE or DONE is ignored. If `cancel` and the final tick coincide in RUN, cancel wins.
- A request still asserted after its own `done` is a new request. It gets no priority over other requesters.
- `busy` = (state != IDLE); it is combinational from the state register.

## Timing
- Reset values: `pc`=0, `tick`=0, `clk_div`=0, `gnt`=0, `done`=0, `busy`=0, `cnt`=0, state=IDLE, `last`=NREQ−1 (so requester 0 has first priority).
- First `tick` after reset falls in cycle `PRESCALE+1`, counting the first post-reset edge as cycle 1.
- Grant latency: `req` sampled in IDLE at edge t; `gnt` high from cycle t+1.
- A `tick` that is high in the IDLE cycle is not counted.
- Delay: `done` rises on the edge that samples the N-th tick seen in RUN. Delay from grant is between `(N−1)*(PRESCALE+1)+1` and `N*(PRESCALE+1)` cycles.
- `req_ticks`=0: DONE directly; `gnt` and `done` are both high in cycle t+1.
- At least one IDLE cycle separates consecutive grants.
- Reset mid-operation: all registers return to reset values at the next edge regardless of state; no `done` is issued.

## Test plan
- Reset, PRESCALE=3, no req:
  - `tick` is high in cycles 4, 8, 12…
  - `clk_div` toggles at each tick (period 8).
  - `gnt`/`done`/`busy` stay 0.
- req=0001, ticks0=3, PRESCALE=3:
  - `gnt`=0001 one cycle after req.
  - `done`=0001 for one cycle after the third counted tick.
  - `gnt` returns to 0 the following cycle.
- req=0100, ticks2=0:
  - Next cycle `gnt`=0100 and `done`=0100 together.
  - IDLE (`busy`=0) in the cycle after.
- req=1111 held, all ticks=1: grant order 0,1,2,3,0, each separated by one IDLE cycle.
- Cancel: req=0011 with ticks=5, `cancel` pulsed during the second tick of requester 0's run:
  - `gnt` goes to 0 the next cycle, with no `done[0]`.
  - The next grant goes to requester 1.
- Reset asserted mid-RUN for requester 2 with req=1111 held:
  - Next cycle all outputs are 0.
  - After release, requester 0 is granted first.
  - `tick` restarts at cycle PRESCALE+1.
